// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receiver and its line/consumer side.
// The slave modport is the receiver's view; master is the environment's view.
interface uart_rx_core_if;
  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output din, input data, input valid, input frame_err, input busy);
  modport slave  (input din, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises din, validates the start bit at its centre,
// samples data bits LSB first at their centres and strobes valid or frame_err.
module uart_rx_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_core_if.slave rx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic             sync1_q, sync2_q, prev_q;
  logic             din_s, fall_s;

  assign din_s  = sync2_q;
  assign fall_s = prev_q & ~sync2_q;

  // Input synchroniser and edge-detect copy; reset high so release looks like idle line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx.din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state and datapath decisions, all taken at mid-bit counter values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!din_s) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = din_s;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (din_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        // A held-low line produces a single error; wait for it to recover
        cnt_d = '0;
        if (din_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = busy_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver for 8N1 frames; it is the receive-side counterpart of the board's switch-driven UART transmit path. It synchronises the serial line, detects and validates start bits, and samples each bit at its centre. It presents each received byte with a one-cycle valid strobe and flags framing errors. It sits between the board RX pin (or a loopback of the local tx) and display or consumer logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division), DIV >= 4 required

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
din  input  1  serial line, idle high, asynchronous to clk
data  output  8  last correctly received byte, held until next good frame
valid  output  1  one-cycle strobe: data just updated
frame_err  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; data=8'h00; valid=0; frame_err=0; busy=0; bit counter=0; baud counter=0.
  - Both synchroniser flops reset to 1 so that reset release never fakes a start bit.
- Input path: 2-flop synchroniser on din gives din_s. A falling-edge detector on din_s uses one further registered copy.
- Baud counter width: clog2(DIV). It counts 0..DIV-1 and restarts at 0 on every state entry.
- State machine:
  - IDLE: on a falling edge of din_s, go to START and clear the baud counter.
  - START: when the count reaches DIV/2-1 (mid start bit), sample din_s.
    - din_s=0: go to DATA with bit index 0 and clear the counter.
    - din_s=1 (false start or glitch): return to IDLE with no strobe.
  - DATA: each time the count reaches DIV-1 (mid data bit), shift din_s into bit [index] of a shift register (LSB first).
    - After index 7 is taken, go to STOP.
  - STOP: at count DIV-1 (mid stop bit), sample din_s.
    - din_s=1: data <= shift register; valid=1 for exactly the next cycle; go to IDLE.
    - din_s=0: frame_err=1 for exactly one cycle; data unchanged; go to BREAK.
  - BREAK: wait until din_s=1, then go to IDLE. A stuck-low line (break condition) therefore yields one frame_err, not repeated errors.
- Latency: valid rises 1 clk after the stop-bit mid-sample. That is about 9.5 bit times plus 3 clk (synchroniser + edge detector) after the start-bit falling edge on din.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre. A start edge arriving half a bit later must be accepted, so no dead time beyond 1 clk is allowed.
- valid and frame_err are never high in the same cycle. Neither strobe is high for more than one consecutive cycle.
- There is no consumer handshake. A consumer that misses a strobe still reads data, which is held until the next good frame.
- A falling edge on din_s while in START, DATA or STOP is ignored; only the mid-bit samples matter.
- Reset asserted mid-frame aborts immediately to the reset values. Any partial byte is discarded, and no strobe is produced after release.

Test Plan:
(Bench parameters CLK_FREQ=160, BAUD=10, so DIV=16.)
- Single frame: send 8'hA5 as 8N1 on din. Required response: exactly one valid pulse, data=8'hA5, frame_err never asserted, busy high from start detection until the valid cycle.
- Back-to-back frames: send 8'h00, 8'hFF, 8'h3C with no idle gap. Required response: three valid pulses in order with data 00, FF, 3C, and no frame_err.
- False start: a low glitch of 4 clk on idle din. Required response: the machine returns to IDLE within DIV/2 + 3 clk, with no valid and no frame_err, and data keeps its previous value.
- Framing error: first a good frame 8'h11, then frame 8'h5A with the stop bit driven 0, then din returned high. Required response: one frame_err pulse with no valid for the second frame, data stays 8'h11, and a following frame 8'h22 is received correctly.
- Break: hold din low for 30 bit times. Required response: exactly one frame_err, busy stays high until din returns high, then normal reception of 8'h81 resumes.
- Reset mid-frame: assert rst=0 during data bit 4 of 8'h77, release it 5 clk later with din high. Required response: all outputs at reset values, no strobe, and the next frame 8'h77 is received correctly.
